// File: rtl/issue_decode_pkg.sv
// issue_decode_pkg: opcodes, control-word layout and decode rows for issue_decode_stage
package issue_decode_pkg;
  localparam int CTRL_W = 14;
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic [1:0] target_src;
  } ctrl_t;
  localparam ctrl_t CTRL_LW    = 14'b1_000_1_0_01_0_00_0_01;
  localparam ctrl_t CTRL_SW    = 14'b0_001_1_1_00_0_00_0_01;
  localparam ctrl_t CTRL_R     = 14'b1_000_0_0_00_0_10_0_01;
  localparam ctrl_t CTRL_B     = 14'b0_010_0_0_00_1_01_0_01;
  localparam ctrl_t CTRL_I     = 14'b1_000_1_0_00_0_10_0_01;
  localparam ctrl_t CTRL_AUIPC = 14'b1_100_0_0_11_0_00_0_01;
  localparam ctrl_t CTRL_LUI   = 14'b1_100_0_0_11_0_00_0_00;
  localparam ctrl_t CTRL_JAL   = 14'b1_011_0_0_10_0_00_1_01;
  localparam ctrl_t CTRL_JALR  = 14'b1_000_1_0_10_0_00_1_10;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/issue_decode_stage_lane_decoder.sv
// lane_decoder: combinational opcode to control-word decode with illegal-opcode flag
module lane_decoder
  import issue_decode_pkg::*;
(
  input  logic [6:0] op_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);
  always_comb begin
    ctrl_o = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_BUBBLE: ctrl_o = '0;
      OP_LW:     ctrl_o = CTRL_LW;
      OP_SW:     ctrl_o = CTRL_SW;
      OP_R:      ctrl_o = CTRL_R;
      OP_B:      ctrl_o = CTRL_B;
      OP_I:      ctrl_o = CTRL_I;
      OP_AUIPC:  ctrl_o = CTRL_AUIPC;
      OP_LUI:    ctrl_o = CTRL_LUI;
      OP_JAL:    ctrl_o = CTRL_JAL;
      OP_JALR:   ctrl_o = CTRL_JALR;
      default:   illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/issue_decode_stage.sv
// issue_decode_stage: registered multi-lane decode with valid/ready, flush and illegal handling.
// Define ISSUE_DECODE_ILLEGAL_TRAP_EN to make illegal opcodes trap instead of decoding as bubbles.
module issue_decode_stage
  import issue_decode_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES-1:0]        in_lane_valid_i,
  input  logic [7*LANES-1:0]      in_op_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES-1:0]        out_lane_valid_o,
  output logic [CTRL_W*LANES-1:0] out_ctrl_o,
  output logic                    illegal_o
);
  ctrl_t                    dec_ctrl [LANES];
  logic [LANES-1:0]         dec_ill, lane_v, lane_q, lane_d;
  logic [CTRL_W*LANES-1:0]  ctrl_w, ctrl_q, ctrl_d;
  state_t                   state_q, state_d;
  logic                     accept;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_decoder u_dec (.op_i(in_op_i[7*i+:7]), .ctrl_o(dec_ctrl[i]), .illegal_o(dec_ill[i]));
  end
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
  logic hit, illegal_q, illegal_d;
`endif
  // An illegal lane (trap build) kills itself and every younger lane above it
  always_comb begin
    lane_v = '0;
    ctrl_w = '0;
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
    hit = 1'b0;
`endif
    for (int k = 0; k < LANES; k++) begin
      lane_v[k] = in_lane_valid_i[k] && !dec_ill[k] && in_op_i[7*k+:7] != OP_BUBBLE;
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
      hit = hit || (in_lane_valid_i[k] && dec_ill[k]);
      lane_v[k] = lane_v[k] && !hit;
`endif
      ctrl_w[CTRL_W*k+:CTRL_W] = lane_v[k] ? dec_ctrl[k] : '0;
    end
  end
  assign out_valid_o = state_q == FULL;
  assign in_ready_o = !illegal_o && (!out_valid_o || out_ready_i);
  assign accept = in_valid_i && in_ready_o && !flush_i;
  always_comb begin
    state_d = flush_i ? EMPTY : accept ? (|lane_v ? FULL : EMPTY) : out_ready_i ? EMPTY : state_q;
    lane_d = flush_i ? '0 : accept ? lane_v : out_ready_i ? '0 : lane_q;
    ctrl_d = flush_i ? '0 : accept ? ctrl_w : out_ready_i ? '0 : ctrl_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      lane_q <= '0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign out_lane_valid_o = lane_q;
  assign out_ctrl_o = ctrl_q;
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
  always_comb illegal_d = flush_i ? 1'b0 : illegal_q || (accept && hit);
  always_ff @(posedge clk) illegal_q <= reset ? 1'b0 : illegal_d;
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif
endmodule

// File: tb/tb_issue_decode_stage.sv
// tb_issue_decode_stage: directed and randomized checks of issue_decode_stage against a table-driven model
module tb_issue_decode_stage;
  localparam int L = 2;
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 0, reset = 1, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic in_ready_o, out_valid_o, illegal_o;
  logic [L-1:0] in_lane_valid_i = '0, out_lane_valid_o;
  logic [7*L-1:0] in_op_i = '0;
  logic [14*L-1:0] out_ctrl_o;
  int checks = 0, failures = 0;
  logic [6:0] ops_t [10] = '{7'b0000000, 7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                             7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111};
  logic [13:0] ctl_t [10] = '{14'b0, 14'b1_000_1_0_01_0_00_0_01, 14'b0_001_1_1_00_0_00_0_01,
                              14'b1_000_0_0_00_0_10_0_01, 14'b0_010_0_0_00_1_01_0_01,
                              14'b1_000_1_0_00_0_10_0_01, 14'b1_100_0_0_11_0_00_0_01,
                              14'b1_100_0_0_11_0_00_0_00, 14'b1_011_0_0_10_0_00_1_01,
                              14'b1_000_1_0_10_0_00_1_10};
  issue_decode_stage #(.LANES(L)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_lane_valid_i(in_lane_valid_i), .in_op_i(in_op_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_lane_valid_o(out_lane_valid_o), .out_ctrl_o(out_ctrl_o),
    .illegal_o(illegal_o));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic void ref_bundle(input logic [1:0] m, input logic [13:0] ops,
                                     output logic [1:0] lm, output logic [27:0] cw, output logic ill);
    logic dead;
    int idx;
    dead = 0; lm = 0; cw = 0; ill = 0;
    for (int k = 0; k < L; k++) begin
      idx = -1;
      for (int j = 0; j < 10; j++) if (ops_t[j] == ops[7*k+:7]) idx = j;
      if (m[k] && idx < 0) begin ill = TRAP; dead = TRAP; end
      if (m[k] && idx > 0 && !dead) begin lm[k] = 1'b1; cw[14*k+:14] = ctl_t[idx]; end
    end
  endfunction
  function automatic logic [6:0] rand_op();
    return ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops_t[$urandom_range(0, 9)];
  endfunction
  function automatic logic [13:0] rand_legal();
    return {ops_t[$urandom_range(1, 9)], ops_t[$urandom_range(1, 9)]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1; in_valid_i = 1; in_lane_valid_i = 2'b11; in_op_i = {7'b0000011, 7'b0110011}; out_ready_i = 1;
    tick(); tick();
    checks++;
    if ({out_valid_o, out_lane_valid_o, out_ctrl_o, illegal_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b lanes=%b ctrl=%h ill=%b, want all 0", out_valid_o, out_lane_valid_o, out_ctrl_o, illegal_o);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    reset = 0; in_valid_i = 0;
    tick();
  endtask
  task automatic test_basic();
    in_valid_i = 1; in_lane_valid_i = 2'b11; in_op_i = {7'b0000011, 7'b0110011}; out_ready_i = 1;
    tick();
    in_valid_i = 0;
    checks++;
    if ({out_valid_o, out_lane_valid_o} !== 3'b111) begin
      failures++; $display("FAIL basic_valid: got v=%b lanes=%b want v=1 lanes=11", out_valid_o, out_lane_valid_o);
    end
    checks++;
    if (out_ctrl_o !== {14'b1_000_1_0_01_0_00_0_01, 14'b1_000_0_0_00_0_10_0_01}) begin
      failures++; $display("FAIL basic_ctrl: got %b", out_ctrl_o);
    end
    tick();
  endtask
  task automatic test_backpressure();
    logic [13:0] a, b;
    logic [1:0] la, lb;
    logic [27:0] ca, cb;
    logic ill;
    a = rand_legal(); b = rand_legal();
    ref_bundle(2'b11, a, la, ca, ill);
    ref_bundle(2'b11, b, lb, cb, ill);
    in_valid_i = 1; in_lane_valid_i = 2'b11; in_op_i = a; out_ready_i = 1;
    tick();
    in_op_i = b; out_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({in_ready_o, out_valid_o, out_lane_valid_o, out_ctrl_o} !== {1'b0, 1'b1, la, ca}) begin
        failures++;
        $display("FAIL stall_hold%0d: got rdy=%b v=%b lanes=%b ctrl=%h want rdy=0 v=1 lanes=%b ctrl=%h",
                 c, in_ready_o, out_valid_o, out_lane_valid_o, out_ctrl_o, la, ca);
      end
    end
    out_ready_i = 1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b want 1", in_ready_o); end
    tick();
    in_valid_i = 0;
    checks++;
    if ({out_valid_o, out_lane_valid_o, out_ctrl_o} !== {1'b1, lb, cb}) begin
      failures++; $display("FAIL stall_new: got v=%b lanes=%b ctrl=%h want v=1 lanes=%b ctrl=%h", out_valid_o, out_lane_valid_o, out_ctrl_o, lb, cb);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL stall_dup: got v=%b want 0", out_valid_o); end
  endtask
  task automatic test_mask();
    in_valid_i = 1; in_lane_valid_i = 2'b01; in_op_i = {7'b1101111, 7'b0110011}; out_ready_i = 1;
    tick();
    in_valid_i = 0;
    checks++;
    if ({out_valid_o, out_lane_valid_o, out_ctrl_o} !== {1'b1, 2'b01, 14'b0, 14'b1_000_0_0_00_0_10_0_01}) begin
      failures++; $display("FAIL mask: got v=%b lanes=%b ctrl=%b", out_valid_o, out_lane_valid_o, out_ctrl_o);
    end
    tick();
  endtask
  task automatic test_illegal();
    in_valid_i = 1; in_lane_valid_i = 2'b11; in_op_i = {7'b1111111, 7'b0010011}; out_ready_i = 1;
    tick();
    in_valid_i = 0;
    checks++;
    if ({out_valid_o, out_lane_valid_o, out_ctrl_o[13:0]} !== {1'b1, 2'b01, 14'b1_000_1_0_00_0_10_0_01}) begin
      failures++; $display("FAIL illegal_lanes: got v=%b lanes=%b ctrl=%b", out_valid_o, out_lane_valid_o, out_ctrl_o);
    end
`ifdef ISSUE_DECODE_ILLEGAL_TRAP_EN
    checks++;
    if ({illegal_o, in_ready_o} !== 2'b10) begin
      failures++; $display("FAIL illegal_trap: got ill=%b rdy=%b want ill=1 rdy=0", illegal_o, in_ready_o);
    end
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    checks++;
    if ({illegal_o, out_valid_o, in_ready_o} !== 3'b001) begin
      failures++; $display("FAIL illegal_flush: got ill=%b v=%b rdy=%b want 0 0 1", illegal_o, out_valid_o, in_ready_o);
    end
`else
    checks++;
    if ({illegal_o, in_ready_o} !== 2'b01) begin
      failures++; $display("FAIL illegal_bubble: got ill=%b rdy=%b want ill=0 rdy=1", illegal_o, in_ready_o);
    end
    tick();
`endif
  endtask
  task automatic test_flush();
    in_valid_i = 1; in_lane_valid_i = 2'b11; in_op_i = rand_legal(); out_ready_i = 1;
    tick();
    in_op_i = rand_legal(); flush_i = 1;
    tick();
    flush_i = 0; in_valid_i = 0;
    checks++;
    if ({out_valid_o, out_lane_valid_o, out_ctrl_o} !== '0) begin
      failures++; $display("FAIL flush_clear: got v=%b lanes=%b ctrl=%h want 0", out_valid_o, out_lane_valid_o, out_ctrl_o);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_drop: got v=%b want 0", out_valid_o); end
  endtask
  task automatic test_back_to_back();
    logic [1:0] lm;
    logic [27:0] cw;
    logic ill;
    in_valid_i = 1; in_lane_valid_i = 2'b11; out_ready_i = 1;
    for (int c = 0; c < 8; c++) begin
      in_op_i = {ops_t[(2*c+1)%10], ops_t[(2*c)%10]};
      ref_bundle(2'b11, in_op_i, lm, cw, ill);
      tick();
      checks++;
      if ({out_valid_o, out_lane_valid_o, out_ctrl_o} !== {|lm, lm, cw}) begin
        failures++;
        $display("FAIL b2b%0d: got v=%b lanes=%b ctrl=%h want v=%b lanes=%b ctrl=%h",
                 c, out_valid_o, out_lane_valid_o, out_ctrl_o, |lm, lm, cw);
      end
    end
    in_valid_i = 0;
    tick();
  endtask
  task automatic test_random();
    logic ev, ei, rdy, hit;
    logic [1:0] el, lm;
    logic [27:0] ec, cw;
    flush_i = 1; in_valid_i = 0;
    tick();
    ev = 0; ei = 0; el = 0; ec = 0;
    for (int n = 0; n < 300; n++) begin
      flush_i = ($urandom_range(0, 7) == 0);
      in_valid_i = 1'($urandom_range(0, 1));
      in_lane_valid_i = 2'($urandom_range(0, 3));
      in_op_i = {rand_op(), rand_op()};
      out_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      rdy = !ei && (!ev || out_ready_i);
      checks++;
      if (in_ready_o !== rdy) begin failures++; $display("FAIL rand_ready%0d: got %b want %b", n, in_ready_o, rdy); end
      ref_bundle(in_lane_valid_i, in_op_i, lm, cw, hit);
      if (flush_i) begin ev = 0; ei = 0; el = 0; ec = 0; end
      else if (in_valid_i && rdy) begin ev = |lm; el = lm; ec = cw; ei = ei || hit; end
      else if (out_ready_i) ev = 0;
      tick();
      checks++;
      if ({out_valid_o, illegal_o} !== {ev, ei}) begin
        failures++; $display("FAIL rand_state%0d: got v=%b ill=%b want v=%b ill=%b", n, out_valid_o, illegal_o, ev, ei);
      end
      if (ev) begin
        checks++;
        if ({out_lane_valid_o, out_ctrl_o} !== {el, ec}) begin
          failures++; $display("FAIL rand_data%0d: got lanes=%b ctrl=%h want lanes=%b ctrl=%h", n, out_lane_valid_o, out_ctrl_o, el, ec);
        end
      end
    end
    flush_i = 0; in_valid_i = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_mask();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_decode_stage.md
# issue_decode_stage

Parametrised multi-lane main-decode pipeline stage for the superscalar front end. Each cycle it accepts a bundle of up to LANES opcodes, decodes each one into the 14-bit main control word, and registers the results behind a valid/ready handshake. It sits between fetch/align and the register-read/issue stage. It adds three things to the single-lane combinational decoder:

- per-lane valid masking
- pipeline flush
- illegal-opcode handling

## Interface
- LANES, 2: number of decode lanes (1–4); lane 0 is oldest.
- CTRL_W, 14: control word width; fixed by package, not overridable.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  squash the held bundle and any incoming bundle this cycle.
- in_valid_i  in  1  upstream bundle valid.
- in_ready_o  out  1  stage can accept this cycle (combinational).
- in_lane_valid_i  in  LANES  per-lane valid mask.
- in_op_i  in  7*LANES  opcodes; lane k occupies bits [7k+6:7k].
- out_valid_o  out  1  registered bundle valid.
- out_ready_i  in  1  downstream accepts.
- out_lane_valid_o  out  LANES  registered lane mask.
- out_ctrl_o  out  CTRL_W*LANES  per-lane control word {RegWrite, ImmSrc[2:0], ALUSrc, MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump, TargetSrc[1:0]}; lane k occupies bits [14k+13:14k].
- illegal_o  out  1  sticky illegal-opcode trap flag.

## Operation
Decode table, with all don't-cares resolved to 0:

- 0000000 (bubble): all fields 0; lane valid cleared.
- 0000011 (lw): 1_000_1_0_01_0_00_0_01.
- 0100011 (sw): 0_001_1_1_00_0_00_0_01.
- 0110011 (R-type): 1_000_0_0_00_0_10_0_01.
- 1100011 (B-type): 0_010_0_0_00_1_01_0_01.
- 0010011 (I-type ALU): 1_000_1_0_00_0_10_0_01.
- 0010111 (auipc): 1_100_0_0_11_0_00_0_01.
- 0110111 (lui): 1_100_0_0_11_0_00_0_00.
- 1101111 (jal): 1_011_0_0_10_0_00_1_01.
- 1100111 (jalr): 1_000_1_0_10_0_00_1_10.
- Any other opcode is illegal: control word 0; see Configuration for the lane-valid and trap consequences.

Handshake and state:

- Lanes with in_lane_valid_i=0 produce control word 0 and out_lane_valid=0.
- A bundle is accepted when in_valid_i && in_ready_o.
- A bundle whose resulting lane mask is all zero is still accepted but does not set out_valid_o.
- in_ready_o = !illegal_o && (!out_valid_o || out_ready_i).
- State machine, two states:
  - EMPTY: out_valid_o=0.
  - FULL: out_valid_o=1.
  - EMPTY→FULL on accept with a non-empty mask.
  - FULL→EMPTY on out_ready_i with no accept.
  - FULL→FULL on simultaneous drain and accept.
- flush_i has priority over everything: next state is EMPTY, lane mask and control words are 0, the incoming bundle is dropped, and illegal_o is cleared.
- While FULL and out_ready_i=0, the output registers hold stable.

## Timing
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 bundle/cycle when out_ready_i stays high.
- Reset values:
  - out_valid_o=0, out_lane_valid_o=0, out_ctrl_o=0, illegal_o=0.
  - in_ready_o=1 after reset.
- reset asserted mid-transfer discards the held bundle; no output toggles during reset.
- flush_i and reset both win over a simultaneous accept.

## Configuration
ISSUE_DECODE_ILLEGAL_TRAP_EN:

- Defined:
  - An illegal opcode in valid lane k sets illegal_o on the registered cycle.
  - Lane k and all lanes above k get lane valid cleared.
  - Lanes below k issue normally.
  - illegal_o stays set, forcing in_ready_o=0, until flush_i or reset.
- Undefined:
  - An illegal opcode decodes as a bubble: control word 0, lane valid cleared, other lanes unaffected.
  - illegal_o is tied 0.

## Structure
- A shared package issue_decode_pkg holds:
  - opcode localparams.
  - ctrl_t packed struct, 14 bits, field order as above.
  - the CTRL_W constant.
  - function-free constants for each decode row.
- One sub-module, lane_decoder: purely combinational, 7-bit opcode in, ctrl_t plus an illegal bit out. It is instantiated LANES times via generate.
- The register/handshake logic lives in the top module.

## Test plan
- Reset, then LANES=2, ops {0110011, 0000011}, mask 11, out_ready_i=1 → next cycle out_valid_o=1, lane0 ctrl 1_000_0_0_00_0_10_0_01, lane1 ctrl 1_000_1_0_01_0_00_0_01.
- Hold out_ready_i=0 for 3 cycles with a new bundle presented → in_ready_o=0, outputs unchanged; raise out_ready_i → new bundle appears the next cycle, with no loss or duplicate.
- Mask 01 with lane1 op 1101111 → out_lane_valid_o=01, lane1 ctrl 0.
- Trap enabled, ops {0010011, 1111111} → out_lane_valid_o=01, illegal_o=1, in_ready_o=0; flush_i one cycle → illegal_o=0, out_valid_o=0, in_ready_o=1.
- flush_i asserted in the same cycle as an accept while FULL → next cycle out_valid_o=0 and the incoming bundle never appears.
- Back-to-back bundles with out_ready_i=1 for 8 cycles → 8 consecutive outputs in order at 1 bundle/cycle; all ten legal opcodes checked against the table.
